// File: rtl/quad_decoder_pkg.sv
// Shared types and helpers for the quadrature decoder.
// Latency: n/a (constants and pure functions only).
// Backpressure: none.
package quad_decoder_pkg;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;

    localparam logic [1:0] GRAY_00 = 2'b00;
    localparam logic [1:0] GRAY_01 = 2'b01;
    localparam logic [1:0] GRAY_11 = 2'b11;
    localparam logic [1:0] GRAY_10 = 2'b10;

    typedef enum logic [1:0] {
        TR_NONE    = 2'd0,
        TR_FWD     = 2'd1,
        TR_REV     = 2'd2,
        TR_ILLEGAL = 2'd3
    } trans_t;

    // The counter only has to reach FILTER_LEN-1.
    function automatic int filt_cnt_width(input int filter_len);
        return (filter_len < 3) ? 1 : $clog2(filter_len);
    endfunction

    function automatic trans_t classify(input logic [1:0] old_p, input logic [1:0] new_p);
        logic [1:0] fwd_next;
        if (old_p == new_p)
            return TR_NONE;
        if ((old_p ^ new_p) == 2'b11)
            return TR_ILLEGAL;
        case (old_p)
            GRAY_00: fwd_next = GRAY_01;
            GRAY_01: fwd_next = GRAY_11;
            GRAY_11: fwd_next = GRAY_10;
            default: fwd_next = GRAY_00;
        endcase
        return (new_p == fwd_next) ? TR_FWD : TR_REV;
    endfunction

endpackage

// File: rtl/quad_decoder_glitch_filter.sv
// Two-flop synchroniser plus stability filter for the A/B pair, with start-up priming.
// Latency: pair update FILTER_LEN+1 edges after a change reaches stage 1.
// Backpressure: none; upd is a one-cycle pulse carrying old/new pair.
module quad_glitch_filter
    import quad_decoder_pkg::*;
#(
    parameter int FILTER_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] din,
    output logic [1:0] pair,
    output logic [1:0] pair_old,
    output logic       upd
);

    localparam int CW = filt_cnt_width(FILTER_LEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [CW-1:0] cnt;
    logic          primed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= 2'b00;
            sync2    <= 2'b00;
            cnt      <= '0;
            primed   <= 1'b0;
            pair     <= 2'b00;
            pair_old <= 2'b00;
            upd      <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            upd   <= 1'b0;
            if (!primed) begin
                // While priming, pair tracks the previous stage-2 value so a
                // stable run can be measured without reporting anything.
                pair <= sync2;
                if (sync2 == pair) begin
                    if (cnt == CNT_LAST) begin
                        primed <= 1'b1;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end else begin
                    cnt <= '0;
                end
            end else if (sync2 != pair) begin
                if (cnt == CNT_LAST) begin
                    pair     <= sync2;
                    pair_old <= pair;
                    upd      <= 1'b1;
                    cnt      <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filtered A/B Gray decode into step pulses and a wrapping position count.
// Latency: step/count update FILTER_LEN+2 edges after a clean A/B change is sampled.
// Backpressure: none; step is a one-cycle pulse, err is sticky until err_clr.
module quad_decoder
    import quad_decoder_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int FILTER_LEN = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enc_a,
    input  logic                  enc_b,
    input  logic                  clear,
    input  logic                  err_clr,
    output logic                  step,
    output logic                  direction,
    output logic [DATA_WIDTH-1:0] count,
    output logic                  err
);

    logic [1:0] pair;
    logic [1:0] pair_old;
    logic       upd;
    trans_t     tr;

    quad_glitch_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_filter (
        .clk      (clk),
        .rst      (rst),
        .din      ({enc_a, enc_b}),
        .pair     (pair),
        .pair_old (pair_old),
        .upd      (upd)
    );

    assign tr = upd ? classify(pair_old, pair) : TR_NONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step      <= 1'b0;
            direction <= DIR_REV;
            count     <= '0;
            err       <= 1'b0;
        end else begin
            step <= (tr == TR_FWD) || (tr == TR_REV);
            if (tr == TR_FWD)
                direction <= DIR_FWD;
            else if (tr == TR_REV)
                direction <= DIR_REV;
            // clear wins over a same-cycle step; the step is still reported.
            if (clear)
                count <= '0;
            else if (tr == TR_FWD)
                count <= count + 1'b1;
            else if (tr == TR_REV)
                count <= count - 1'b1;
            err <= (tr == TR_ILLEGAL) || (err && !err_clr);
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder: scoreboard of expected steps plus scenario tasks.
module tb_quad_decoder;

    localparam int FL = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enc_a = 1'b0;
    logic       enc_b = 1'b0;
    logic       clear = 1'b0;
    logic       err_clr = 1'b0;
    logic       step;
    logic       direction;
    logic [3:0] count;
    logic       err;

    int         tests = 0;
    int         failed = 0;
    int         cyc = 0;
    int         step_cyc = -1;
    logic [4:0] exp_q[$];
    logic [1:0] cur = 2'b00;
    logic [3:0] exp_count = 4'd0;

    quad_decoder #(.DATA_WIDTH(4), .FILTER_LEN(FL)) dut (
        .clk       (clk),
        .rst       (rst),
        .enc_a     (enc_a),
        .enc_b     (enc_b),
        .clear     (clear),
        .err_clr   (err_clr),
        .step      (step),
        .direction (direction),
        .count     (count),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic int gpos(input logic [1:0] p);
        case (p)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    // 1 = forward, 3 = reverse, 2 = illegal, 0 = none
    function automatic int tb_trans(input logic [1:0] o, input logic [1:0] n);
        return (gpos(n) - gpos(o) + 4) % 4;
    endfunction

    function automatic logic [1:0] nxt_fwd(input logic [1:0] p);
        logic [1:0] seq [4];
        seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b11; seq[3] = 2'b10;
        return seq[(gpos(p) + 1) % 4];
    endfunction

    // Advance one cycle; any step seen is matched against the scoreboard.
    task automatic sb_cycle();
        logic [4:0] e;
        @(negedge clk);
        cyc++;
        if (step === 1'b1) begin
            tests++;
            step_cyc = cyc;
            if (exp_q.size() == 0) begin
                failed++;
                $display("FAIL unexpected_step dir=%b count=%0d (no step expected)", direction, count);
            end else begin
                e = exp_q.pop_front();
                if ({direction, count} !== e) begin
                    failed++;
                    $display("FAIL step_result dir/count=%b/%0d expected %b/%0d",
                             direction, count, e[4], e[3:0]);
                end
            end
        end
    endtask

    task automatic drain();
        int budget = 40;
        while (exp_q.size() > 0 && budget > 0) begin
            sb_cycle();
            budget--;
        end
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL missing_step pending=%0d expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic go(input logic [1:0] np, input int hold);
        int t;
        t = tb_trans(cur, np);
        {enc_a, enc_b} = np;
        if (t == 1) begin
            exp_count = exp_count + 4'd1;
            exp_q.push_back({1'b1, exp_count});
        end else if (t == 3) begin
            exp_count = exp_count - 4'd1;
            exp_q.push_back({1'b0, exp_count});
        end
        cur = np;
        repeat (hold) sb_cycle();
    endtask

    task automatic check_count(input string name);
        tests++;
        if (count !== exp_count) begin
            failed++;
            $display("FAIL %s count=%0d expected %0d", name, count, exp_count);
        end
    endtask

    task automatic do_reset(input logic [1:0] p);
        rst = 1'b1;
        {enc_a, enc_b} = p;
        clear = 1'b0;
        err_clr = 1'b0;
        exp_q.delete();
        repeat (3) sb_cycle();
        rst = 1'b0;
        cur = p;
        exp_count = 4'd0;
    endtask

    task automatic test_reset();
        do_reset(2'b11);
        tests++;
        if ({step, direction, count, err} !== 7'd0) begin
            failed++;
            $display("FAIL reset_state outputs=%b expected 0000000", {step, direction, count, err});
        end
        repeat (10) sb_cycle();
        check_count("idle_count");
        tests++;
        if (err !== 1'b0) begin
            failed++;
            $display("FAIL idle_err err=%b expected 0", err);
        end
    endtask

    task automatic test_forward();
        int cyc0;
        do_reset(2'b00);
        repeat (12) sb_cycle();
        cyc0 = cyc;
        go(2'b01, 8);
        tests++;
        if (step_cyc - cyc0 !== FL + 3) begin
            failed++;
            $display("FAIL first_step_latency cycles=%0d expected %0d", step_cyc - cyc0, FL + 3);
        end
        go(2'b11, 8);
        go(2'b10, 8);
        go(2'b00, 8);
        drain();
        check_count("forward_count");
        tests++;
        if (direction !== 1'b1) begin
            failed++;
            $display("FAIL forward_dir dir=%b expected 1", direction);
        end
    endtask

    task automatic test_wrap();
        clear = 1'b1;
        sb_cycle();
        clear = 1'b0;
        sb_cycle();
        exp_count = 4'd0;
        check_count("clear_idle");
        go(2'b10, 8);
        drain();
        check_count("reverse_wrap");
        tests++;
        if (direction !== 1'b0) begin
            failed++;
            $display("FAIL reverse_dir dir=%b expected 0", direction);
        end
        for (int i = 0; i < 16; i++) go(nxt_fwd(cur), 8);
        drain();
        check_count("forward_wrap16");
    endtask

    task automatic test_glitch();
        go(2'b00, 8);
        drain();
        {enc_a, enc_b} = 2'b10;
        repeat (FL - 1) sb_cycle();
        {enc_a, enc_b} = 2'b00;
        repeat (12) sb_cycle();
        check_count("glitch_rejected");
        go(2'b01, FL);
        go(2'b00, 12);
        drain();
        check_count("min_pulse_accepted");
    endtask

    task automatic test_illegal();
        go(2'b11, 10);
        tests++;
        if (err !== 1'b1) begin
            failed++;
            $display("FAIL illegal_err err=%b expected 1", err);
        end
        check_count("illegal_count");
        err_clr = 1'b1;
        sb_cycle();
        err_clr = 1'b0;
        tests++;
        if (err !== 1'b0) begin
            failed++;
            $display("FAIL err_clr err=%b expected 0", err);
        end
        go(2'b00, FL + 2);
        tests++;
        if (err !== 1'b0) begin
            failed++;
            $display("FAIL err_early err=%b expected 0", err);
        end
        err_clr = 1'b1;
        sb_cycle();
        err_clr = 1'b0;
        tests++;
        if (err !== 1'b1) begin
            failed++;
            $display("FAIL err_set_wins err=%b expected 1", err);
        end
        repeat (4) sb_cycle();
        check_count("illegal2_count");
    endtask

    task automatic test_clear_and_reset();
        logic [1:0] np;
        for (int i = 0; i < 7; i++) go(nxt_fwd(cur), 8);
        drain();
        check_count("count_seven");
        np = nxt_fwd(cur);
        {enc_a, enc_b} = np;
        cur = np;
        exp_count = 4'd0;
        exp_q.push_back({1'b1, 4'd0});
        repeat (FL + 2) sb_cycle();
        clear = 1'b1;
        sb_cycle();
        clear = 1'b0;
        drain();
        check_count("clear_beats_step");
        np = nxt_fwd(cur);
        {enc_a, enc_b} = np;
        repeat (2) sb_cycle();
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({step, direction, count, err} !== 7'd0) begin
            failed++;
            $display("FAIL async_reset outputs=%b expected 0000000", {step, direction, count, err});
        end
        repeat (2) sb_cycle();
        rst = 1'b0;
        cur = np;
        exp_count = 4'd0;
        repeat (15) sb_cycle();
        check_count("post_reset_idle");
        go(nxt_fwd(cur), 8);
        drain();
        check_count("post_reset_step");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_forward();
        test_wrap();
        test_glitch();
        test_illegal();
        test_clear_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
